// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 scan controller: FSM states, colour field
// offsets inside a frame-buffer word and the default parameter values.
package hub75_pkg;

    localparam int DEF_PANEL_WIDTH    = 32;
    localparam int DEF_ROW_ADDR_BITS  = 2;
    localparam int DEF_COLOR_BITS     = 3;
    localparam int DEF_OE_BASE_CYCLES = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_LATCH   = 2'd2,
        ST_DISPLAY = 2'd3
    } hub75_state_e;

    // Field index within {r1,g1,b1,r2,g2,b2}; bit offset = index * COLOR_BITS.
    localparam int NUM_FIELDS = 6;
    localparam int FLD_R1     = 5;
    localparam int FLD_G1     = 4;
    localparam int FLD_B1     = 3;
    localparam int FLD_R2     = 2;
    localparam int FLD_G2     = 1;
    localparam int FLD_B2     = 0;

    // Counter width that holds the longest display time (top bit-plane).
    function automatic int oe_cnt_width(input int base, input int color_bits);
        return $clog2((base << (color_bits - 1)) + 1);
    endfunction

endpackage

// File: rtl/hub75_oe_timer.sv
// Loadable down-counter timing the OE-low display window; done is high during
// the final cycle of a window of 'value' cycles that starts the cycle after load.
module hub75_oe_timer
    import hub75_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == W'(1));

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 panel scan controller: shifts a row from the frame buffer, latches it,
// then shows it for a bit-plane-weighted time. Define HUB75_BCM_EN for BCM planes.
module hub75_scan_ctrl
    import hub75_pkg::*;
#(
    parameter int PANEL_WIDTH    = DEF_PANEL_WIDTH,
    parameter int ROW_ADDR_BITS  = DEF_ROW_ADDR_BITS,
    parameter int COLOR_BITS     = DEF_COLOR_BITS,
    parameter int OE_BASE_CYCLES = DEF_OE_BASE_CYCLES
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          enable,
    output logic                                          fb_rd_en,
    output logic [ROW_ADDR_BITS+$clog2(PANEL_WIDTH)-1:0]  fb_addr,
    input  logic [NUM_FIELDS*COLOR_BITS-1:0]              fb_rdata,
    output logic                                          CLK_MOD,
    output logic                                          LAT,
    output logic                                          OE,
    output logic                                          A,
    output logic                                          B,
    output logic                                          R1,
    output logic                                          G1,
    output logic                                          B1,
    output logic                                          R2,
    output logic                                          G2,
    output logic                                          B2,
    output logic                                          frame_done,
    output hub75_state_e                                  state_dbg
);

`ifdef HUB75_BCM_EN
    localparam int PLANES = COLOR_BITS;
`else
    localparam int PLANES = 1;
`endif

    localparam int COL_W   = $clog2(PANEL_WIDTH);
    localparam int SH_W    = COL_W + 2;
    localparam int RD_W    = NUM_FIELDS * COLOR_BITS;
    localparam int IDX_W   = $clog2(RD_W);
    localparam int PLANE_W = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
    localparam int CNT_W   = oe_cnt_width(OE_BASE_CYCLES, COLOR_BITS);

    localparam logic [SH_W-1:0]          SH_LAST    = SH_W'(2 * PANEL_WIDTH);
    localparam logic [PLANE_W-1:0]       PLANE_LAST = PLANE_W'(PLANES - 1);
    localparam logic [ROW_ADDR_BITS-1:0] ROW_LAST   = '1;

    hub75_state_e             state_q, state_d;
    logic [ROW_ADDR_BITS-1:0] row_q, row_d;
    logic [PLANE_W-1:0]       plane_q, plane_d;
    logic [SH_W-1:0]          sh_cnt_q, sh_cnt_d;
    logic [ROW_ADDR_BITS-1:0] ab_q, ab_d;
    logic [NUM_FIELDS-1:0]    color_q, color_d;

    logic [NUM_FIELDS-1:0]    plane_bits;
    logic [NUM_FIELDS-1:0]    pix;
    logic [ROW_ADDR_BITS-1:0] ab_out;
    logic [1:0]               ab_pins;
    logic                     timer_load;
    logic                     oe_done;
    logic [CNT_W-1:0]         oe_value;

    always_comb begin
        plane_bits = '0;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            plane_bits[f] = fb_rdata[IDX_W'(f * COLOR_BITS + int'(plane_q))];
        end
    end

    assign oe_value = CNT_W'(OE_BASE_CYCLES) << plane_q;

    hub75_oe_timer #(
        .W(CNT_W)
    ) u_oe_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (timer_load),
        .value (oe_value),
        .done  (oe_done)
    );

    // SHIFT step counter k: reads on even k < 2*W, phase0 on odd k, phase1 on even k > 0.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        plane_d    = plane_q;
        sh_cnt_d   = sh_cnt_q;
        ab_d       = ab_q;
        color_d    = color_q;
        timer_load = 1'b0;
        fb_rd_en   = 1'b0;
        fb_addr    = '0;
        CLK_MOD    = 1'b0;
        LAT        = 1'b0;
        OE         = 1'b1;
        pix        = '0;
        ab_out     = ab_q;
        frame_done = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d  = ST_SHIFT;
                    row_d    = '0;
                    plane_d  = '0;
                    sh_cnt_d = '0;
                end
            end

            ST_SHIFT: begin
                if (!sh_cnt_q[0] && (sh_cnt_q != SH_LAST)) begin
                    fb_rd_en = 1'b1;
                    fb_addr  = {row_q, sh_cnt_q[COL_W:1]};
                end
                if (sh_cnt_q[0]) begin
                    pix     = plane_bits;
                    color_d = plane_bits;
                end else if (sh_cnt_q != '0) begin
                    pix     = color_q;
                    CLK_MOD = 1'b1;
                end
                if (!enable) begin
                    state_d  = ST_IDLE;
                    row_d    = '0;
                    plane_d  = '0;
                    sh_cnt_d = '0;
                end else if (sh_cnt_q == SH_LAST) begin
                    state_d  = ST_LATCH;
                    sh_cnt_d = '0;
                end else begin
                    sh_cnt_d = sh_cnt_q + SH_W'(1);
                end
            end

            ST_LATCH: begin
                LAT    = 1'b1;
                ab_out = row_q;
                ab_d   = row_q;
                if (!enable) begin
                    state_d  = ST_IDLE;
                    row_d    = '0;
                    plane_d  = '0;
                    sh_cnt_d = '0;
                end else begin
                    state_d    = ST_DISPLAY;
                    timer_load = 1'b1;
                end
            end

            ST_DISPLAY: begin
                OE = 1'b0;
                if (oe_done) begin
                    if (plane_q == PLANE_LAST) begin
                        plane_d    = '0;
                        row_d      = row_q + ROW_ADDR_BITS'(1);
                        frame_done = (row_q == ROW_LAST);
                    end else begin
                        plane_d = plane_q + PLANE_W'(1);
                    end
                    // Enable is only honoured at the end of the display window.
                    if (enable) begin
                        state_d  = ST_SHIFT;
                        sh_cnt_d = '0;
                    end else begin
                        state_d  = ST_IDLE;
                        row_d    = '0;
                        plane_d  = '0;
                        sh_cnt_d = '0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            plane_q  <= '0;
            sh_cnt_q <= '0;
            ab_q     <= '0;
            color_q  <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            plane_q  <= plane_d;
            sh_cnt_q <= sh_cnt_d;
            ab_q     <= ab_d;
            color_q  <= color_d;
        end
    end

    assign ab_pins   = 2'(ab_out);
    assign A         = ab_pins[0];
    assign B         = ab_pins[1];
    assign R1        = pix[FLD_R1];
    assign G1        = pix[FLD_G1];
    assign B1        = pix[FLD_B1];
    assign R2        = pix[FLD_R2];
    assign G2        = pix[FLD_G2];
    assign B2        = pix[FLD_B2];
    assign state_dbg = state_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Scoreboard bench for hub75_scan_ctrl: a frame-level model pushes expected reads,
// pixels, latches and display windows; a negedge monitor pops and compares.
module tb_hub75_scan_ctrl;
    import hub75_pkg::*;

    localparam int PW     = 32;
    localparam int RAB    = 2;
    localparam int CB     = 3;
    localparam int OEB    = 4;
    localparam int ROWS   = 1 << RAB;
    localparam int COL_W  = 5;
    localparam int ADDR_W = RAB + COL_W;
    localparam int RD_W   = 6 * CB;
`ifdef HUB75_BCM_EN
    localparam int PLANES = CB;
`else
    localparam int PLANES = 1;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    always #5 clk = ~clk;

    logic              fb_rd_en;
    logic [ADDR_W-1:0] fb_addr;
    logic [RD_W-1:0]   fb_rdata = '0;
    logic              CLK_MOD, LAT, OE, A, B, R1, G1, B1, R2, G2, B2, frame_done;
    hub75_state_e      state_dbg;

    hub75_scan_ctrl #(
        .PANEL_WIDTH    (PW),
        .ROW_ADDR_BITS  (RAB),
        .COLOR_BITS     (CB),
        .OE_BASE_CYCLES (OEB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fb_rd_en   (fb_rd_en),
        .fb_addr    (fb_addr),
        .fb_rdata   (fb_rdata),
        .CLK_MOD    (CLK_MOD),
        .LAT        (LAT),
        .OE         (OE),
        .A          (A),
        .B          (B),
        .R1         (R1),
        .G1         (G1),
        .B1         (B1),
        .R2         (R2),
        .G2         (G2),
        .B2         (B2),
        .frame_done (frame_done),
        .state_dbg  (state_dbg)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame buffer memory (1-cycle read latency) ----------------
    logic [RD_W-1:0]   fb_mem [ROWS][PW];
    logic              pend;
    logic [ADDR_W-1:0] pend_addr;

    initial begin
        pend = 1'b0;
        pend_addr = '0;
        forever begin
            @(negedge clk);
            pend = fb_rd_en;
            pend_addr = fb_addr;
            @(posedge clk);
            #1;
            fb_rdata = pend ? fb_mem[pend_addr[6:5]][pend_addr[4:0]] : RD_W'($urandom);
        end
    end

    task automatic fill_fb();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < PW; c++)
                fb_mem[2'(r)][5'(c)] = RD_W'($urandom);
    endtask

    // ---------------- reference model / expected queues ----------------
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [5:0]        exp_pix_q[$];
    logic [RAB-1:0]    exp_lat_q[$];
    int                exp_oe_q[$];
    bit                exp_fd_q[$];

    function automatic logic [5:0] pixel_of(input logic [RD_W-1:0] w, input int plane);
        logic [RD_W-1:0] t;
        logic [5:0] px;
        for (int f = 0; f < 6; f++) begin
            t = w >> (f * CB + plane);
            px[f] = t[0];
        end
        return px;
    endfunction

    // Expected events for n consecutive (row, plane) scans starting at row 0, plane 0.
    task automatic push_planes(input int n);
        int row;
        int plane;
        row = 0;
        plane = 0;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < PW; c++) begin
                exp_addr_q.push_back(ADDR_W'(row * PW + c));
                exp_pix_q.push_back(pixel_of(fb_mem[2'(row)][5'(c)], plane));
            end
            exp_lat_q.push_back(RAB'(row));
            exp_oe_q.push_back(OEB << plane);
            exp_fd_q.push_back((row == ROWS - 1) && (plane == PLANES - 1));
            plane++;
            if (plane == PLANES) begin
                plane = 0;
                row = (row + 1) % ROWS;
            end
        end
    endtask

    function automatic int pending();
        return exp_addr_q.size() + exp_pix_q.size() + exp_lat_q.size() + exp_oe_q.size();
    endfunction

    // ---------------- monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit                mon_off = 1'b0;
    bit                prev_clk_mod, in_low, rd_seen, fd_last;
    logic [5:0]        pix_now, prev_pix, e_pix;
    logic [ADDR_W-1:0] e_addr;
    logic [RAB-1:0]    e_row;
    int                e_oe;
    bit                e_fd;
    int                low_len, fd_cnt, last_rd_cyc;
    int                first_rd_cyc = -1000;
    int                lat_cyc = -1000;
    int                lat_cnt = 0;
    int                clk_rises = 0;

    always @(negedge clk) begin
        pix_now = {R1, G1, B1, R2, G2, B2};
        if (!rst || mon_off) begin
            prev_clk_mod = 1'b0;
            in_low = 1'b0;
            rd_seen = 1'b0;
            prev_pix = '0;
        end else begin
            if (fb_rd_en) begin
                if (rd_seen && fb_addr[COL_W-1:0] != '0)
                    check(cyc - last_rd_cyc == 2, "rd_spacing", cyc - last_rd_cyc, 2);
                if (fb_addr[COL_W-1:0] == '0) first_rd_cyc = cyc;
                rd_seen = 1'b1;
                last_rd_cyc = cyc;
                if (exp_addr_q.size() == 0) check(1'b0, "rd_unexpected", int'(fb_addr), -1);
                else begin
                    e_addr = exp_addr_q.pop_front();
                    check(fb_addr == e_addr, "rd_addr", int'(fb_addr), int'(e_addr));
                end
            end
            if (CLK_MOD && !prev_clk_mod) begin
                clk_rises++;
                check(pix_now == prev_pix, "pix_hold", int'(pix_now), int'(prev_pix));
                if (exp_pix_q.size() == 0) check(1'b0, "pix_unexpected", int'(pix_now), -1);
                else begin
                    e_pix = exp_pix_q.pop_front();
                    check(pix_now == e_pix, "pix_data", int'(pix_now), int'(e_pix));
                end
            end
            if (LAT) begin
                lat_cnt++;
                lat_cyc = cyc;
                check(cyc - first_rd_cyc == 2 * PW + 1, "shift_len", cyc - first_rd_cyc, 2 * PW + 1);
                check(OE && !CLK_MOD, "lat_oe_clk", int'({OE, CLK_MOD}), 2);
                if (exp_lat_q.size() == 0) check(1'b0, "lat_unexpected", int'({B, A}), -1);
                else begin
                    e_row = exp_lat_q.pop_front();
                    check({B, A} == e_row, "lat_row", int'({B, A}), int'(e_row));
                end
            end
            if (!OE) begin
                if (!in_low) begin
                    in_low = 1'b1;
                    low_len = 0;
                    fd_cnt = 0;
                    check(cyc == lat_cyc + 1, "oe_start", cyc - lat_cyc, 1);
                end
                low_len++;
                fd_cnt += int'(frame_done);
                fd_last = frame_done;
            end else begin
                if (in_low) begin
                    in_low = 1'b0;
                    if (exp_oe_q.size() == 0) check(1'b0, "oe_unexpected", low_len, -1);
                    else begin
                        e_oe = exp_oe_q.pop_front();
                        e_fd = exp_fd_q.pop_front();
                        check(low_len == e_oe, "oe_len", low_len, e_oe);
                        check(fd_cnt == int'(e_fd) && fd_last == e_fd, "frame_done", fd_cnt, int'(e_fd));
                    end
                end
                if (frame_done) check(1'b0, "fd_outside", 1, 0);
            end
            prev_clk_mod = CLK_MOD;
            prev_pix = pix_now;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_idle_outputs(input string tag);
        check(OE === 1'b1, {tag, "_oe"}, int'(OE), 1);
        check({fb_rd_en, CLK_MOD, LAT, A, B, R1, G1, B1, R2, G2, B2, frame_done} === 12'h000,
              {tag, "_outs"}, int'({fb_rd_en, CLK_MOD, LAT, A, B, R1, G1, B1, R2, G2, B2, frame_done}), 0);
        check(fb_addr === '0, {tag, "_addr"}, int'(fb_addr), 0);
    endtask

    task automatic wait_lat(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (lat_cnt < target && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        check(lat_cnt >= target, {tag, "_lat_timeout"}, lat_cnt, target);
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n;
        n = 0;
        while (pending() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(pending() == 0, {tag, "_drain"}, pending(), 0);
        repeat (12) @(negedge clk);
    endtask

    // Scan n planes from row 0, dropping enable inside the final display window.
    task automatic run_planes(input int n, input string tag);
        int lat0;
        lat0 = lat_cnt;
        push_planes(n);
        @(negedge clk);
        #2 enable = 1'b1;
        wait_lat(lat0 + n, n * (2 * PW + 2 + (OEB << (PLANES - 1))) + 100, tag);
        @(negedge clk);
        #2 enable = 1'b0;
        wait_drain(200, tag);
    endtask

    // ---------------- stimulus ----------------
    int rise0, lat0, n;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check(state_dbg == ST_IDLE, "reset_state", int'(state_dbg), int'(ST_IDLE));
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Full frame plus one extra row: {B,A} 0,1,2,3,0 and one frame_done
        fill_fb();
        for (int c = 0; c < PW; c++) fb_mem[0][5'(c)][17:15] = 3'b101;
        run_planes(ROWS * PLANES + PLANES, "frame");

        // Enable drop at column 10 of SHIFT
        fill_fb();
        rise0 = clk_rises;
        lat0 = lat_cnt;
        for (int c = 0; c <= 10; c++) exp_addr_q.push_back(ADDR_W'(c));
        for (int c = 0; c < 10; c++) exp_pix_q.push_back(pixel_of(fb_mem[0][5'(c)], 0));
        @(negedge clk);
        #2 enable = 1'b1;
        n = 0;
        while (clk_rises - rise0 < 10 && n < 500) begin
            @(negedge clk);
            #2;
            n++;
        end
        enable = 1'b0;
        check(clk_rises - rise0 == 10, "abort_cols", clk_rises - rise0, 10);
        @(negedge clk);
        check(OE === 1'b1 && fb_rd_en === 1'b0 && CLK_MOD === 1'b0, "abort_idle",
              int'({OE, fb_rd_en, CLK_MOD}), 4);
        repeat (20) @(negedge clk);
        check(lat_cnt == lat0, "abort_no_lat", lat_cnt - lat0, 0);
        wait_drain(50, "abort");

        // Restart after abort begins at row 0, plane 0
        fill_fb();
        run_planes(2 * PLANES, "restart");

        // Asynchronous reset in the middle of a display window
        fill_fb();
        lat0 = lat_cnt;
        push_planes(1);
        @(negedge clk);
        #2 enable = 1'b1;
        wait_lat(lat0 + 1, 200, "rst_disp");
        @(negedge clk);
        @(negedge clk);
        check(OE === 1'b0, "pre_rst_in_display", int'(OE), 0);
        #3;
        mon_off = 1'b1;
        rst = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        enable = 1'b0;
        exp_addr_q.delete();
        exp_pix_q.delete();
        exp_lat_q.delete();
        exp_oe_q.delete();
        exp_fd_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        mon_off = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst_release");
        repeat (5) @(negedge clk);
        check(OE === 1'b1 && fb_rd_en === 1'b0, "idle_hold", int'({OE, fb_rd_en}), 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
